// File: rtl/spu32_cpu_encoder_pkg.sv
// Shared definitions for the spu32 instruction encoder: opcode/funct3 codes,
// instruction formats, LI expansion kinds and small packing helpers.
package spu32_cpu_encoder_pkg;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  localparam logic [2:0] FUNC_ADDI = 3'b000;
  localparam logic [2:0] FUNC_SLLI = 3'b001;
  localparam logic [2:0] FUNC_SRXI = 3'b101;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;

  typedef enum logic [1:0] {LI_ADDI_ONLY, LI_LUI_ONLY, LI_LUI_ADDI} li_op_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_PAIR} state_t;

  // Unknown opcodes fall back to I-type so every request produces some word.
  function automatic fmt_t fmt_of(input logic [4:0] opcode);
    case (opcode)
      OP_OP:            return FMT_R;
      OP_STORE:         return FMT_S;
      OP_BRANCH:        return FMT_B;
      OP_LUI, OP_AUIPC: return FMT_U;
      OP_JAL:           return FMT_J;
      default:          return FMT_I;
    endcase
  endfunction

  function automatic logic fits_simm12(input logic [31:0] value);
    return ($signed(value) >= -32'sd2048) && ($signed(value) <= 32'sd2047);
  endfunction

  function automatic logic [31:0] enc_itype(input logic [11:0] imm, input logic [4:0] rs1,
                                            input logic [2:0] funct3, input logic [4:0] rd,
                                            input logic [4:0] opcode);
    return {imm, rs1, funct3, rd, opcode, 2'b11};
  endfunction

  function automatic logic [31:0] enc_utype(input logic [19:0] hi, input logic [4:0] rd,
                                            input logic [4:0] opcode);
    return {hi, rd, opcode, 2'b11};
  endfunction

endpackage

// File: rtl/spu32_cpu_encoder_pack.sv
// Combinational field packer: builds one RV32 word for the given format and
// reports whether the immediate is representable in that format.
module spu32_cpu_encoder_pack
  import spu32_cpu_encoder_pkg::*;
(
  input  fmt_t        fmt,
  input  logic [4:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        range_ok
);

  logic is_shift;

  assign is_shift = (opcode == OP_OPIMM) && ((funct3 == FUNC_SLLI) || (funct3 == FUNC_SRXI));

  always_comb begin
    word     = 32'h0000_0003;
    range_ok = 1'b1;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode, 2'b11};
      FMT_I: begin
        if (is_shift) begin
          word     = {funct7, imm[4:0], rs1, funct3, rd, opcode, 2'b11};
          range_ok = (imm < 32'd32);
        end else begin
          word     = enc_itype(imm[11:0], rs1, funct3, rd, opcode);
          range_ok = fits_simm12(imm);
        end
      end
      FMT_S: begin
        word     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode, 2'b11};
        range_ok = fits_simm12(imm);
      end
      FMT_B: begin
        word     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode, 2'b11};
        range_ok = ($signed(imm) >= -32'sd4096) && ($signed(imm) <= 32'sd4094) && !imm[0];
      end
      FMT_U: begin
        word     = enc_utype(imm[31:12], rd, opcode);
        range_ok = (imm[11:0] == 12'h000);
      end
      FMT_J: begin
        word     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode, 2'b11};
        range_ok = ($signed(imm) >= -32'sd1048576) && ($signed(imm) <= 32'sd1048574) && !imm[0];
      end
      default: begin
        word     = 32'h0000_0003;
        range_ok = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/spu32_cpu_encoder.sv
// spu32 instruction encoder: valid/ready request in, packed RV32 word out,
// with LI expanded into LUI (+ADDI) and a one-cycle error pulse on bad immediates.
module spu32_cpu_encoder
  import spu32_cpu_encoder_pkg::*;
(
  input  logic        I_clk,
  input  logic        I_reset_n,
  input  logic        I_valid,
  output logic        O_ready,
  input  logic        I_li,
  input  logic [4:0]  I_opcode,
  input  logic [4:0]  I_rd,
  input  logic [4:0]  I_rs1,
  input  logic [4:0]  I_rs2,
  input  logic [2:0]  I_funct3,
  input  logic [6:0]  I_funct7,
  input  logic [31:0] I_imm,
  output logic        O_valid,
  input  logic        I_ready,
  output logic [31:0] O_instr,
  output logic        O_err
);

  state_t      state, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pend_q, pend_d;
  logic        err_q, err_d;

  fmt_t        fmt;
  logic [31:0] raw_word;
  logic        raw_ok;
  li_op_t      li_op;
  logic [19:0] li_hi;
  logic [31:0] word0, word1;
  logic        req_ok, req_two, accept, xfer;

  assign fmt = fmt_of(I_opcode);

  spu32_cpu_encoder_pack u_pack (
    .fmt      (fmt),
    .opcode   (I_opcode),
    .rd       (I_rd),
    .rs1      (I_rs1),
    .rs2      (I_rs2),
    .funct3   (I_funct3),
    .funct7   (I_funct7),
    .imm      (I_imm),
    .word     (raw_word),
    .range_ok (raw_ok)
  );

  // The +0x800 rounding on hi compensates for ADDI sign-extending lo.
  always_comb begin
    li_hi = 20'((I_imm + 32'h0000_0800) >> 12);
    li_op = LI_ADDI_ONLY;
    if (!fits_simm12(I_imm))
      li_op = (I_imm[11:0] == 12'h000) ? LI_LUI_ONLY : LI_LUI_ADDI;

    word0   = raw_word;
    word1   = enc_itype(I_imm[11:0], I_rd, FUNC_ADDI, I_rd, OP_OPIMM);
    req_ok  = raw_ok;
    req_two = 1'b0;
    if (I_li) begin
      req_ok  = 1'b1;
      req_two = (li_op == LI_LUI_ADDI);
      word0   = (li_op == LI_ADDI_ONLY) ? enc_itype(I_imm[11:0], 5'd0, FUNC_ADDI, I_rd, OP_OPIMM)
                                        : enc_utype(li_hi, I_rd, OP_LUI);
    end
  end

  assign O_ready = (state == ST_EMPTY) || ((state == ST_ONE) && I_ready);
  assign O_valid = (state != ST_EMPTY);
  assign O_instr = instr_q;
  assign O_err   = err_q;
  assign accept  = I_valid && O_ready;
  assign xfer    = O_valid && I_ready;

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state   <= ST_EMPTY;
      instr_q <= 32'h0;
      pend_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_d;
      instr_q <= instr_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  // A new request is only ever accepted when the output slot is free or being freed.
  always_comb begin
    state_d = state;
    instr_d = instr_q;
    pend_d  = pend_q;
    err_d   = 1'b0;
    case (state)
      ST_EMPTY, ST_ONE: begin
        if (xfer) state_d = ST_EMPTY;
        if (accept) begin
          if (req_ok) begin
            instr_d = word0;
            pend_d  = word1;
            state_d = req_two ? ST_PAIR : ST_ONE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_PAIR: begin
        if (xfer) begin
          instr_d = pend_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

endmodule
